mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single word-addressed memory port between the CPU (requester 0) and a second bus master (requester 1, DMA/loader). Grants are issued combinationally in the request cycle, with round-robin fairness. A lock input lets the current owner keep the port across back-to-back cycles, as needed for a two-word misaligned load/store. Sits between the masters and the memory; the memory read is combinational, so read data returns in the granted cycle.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single word-addressed memory port.
// Zero-latency grants, round-robin on ties, and a bounded lock for multi-word accesses.
module mem_arbiter #(
    parameter int MAX_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:2] addr0,
    input  logic [31:2] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  we0,
    input  logic [3:0]  we1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:2] address,
    output logic [31:0] memory_in,
    output logic [3:0]  write_enable,
    input  logic [31:0] memory_out,
    output logic        busy
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MAX_HOLD_W = HW'(MAX_HOLD);
    localparam logic [HW-1:0] ONE_W      = HW'(1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_R0   = 2'd1,
        OWN_R1   = 2'd2
    } owner_t;

    owner_t          r_owner;
    owner_t          w_owner_next;
    logic            r_last;
    logic            w_last_next;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_next;
    logic [HW-1:0]   w_hold_inc;
    logic            w_win0;
    logic            w_win1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
            r_hold  <= '0;
            r_last  <= 1'b1;
        end else begin
            r_owner <= w_owner_next;
            r_hold  <= w_hold_next;
            r_last  <= w_last_next;
        end
    end

    // Winner selection and next-state; an owner only keeps the port while it still requests.
    always_comb begin
        w_win0       = 1'b0;
        w_win1       = 1'b0;
        w_owner_next = OWN_NONE;
        w_hold_next  = '0;
        w_last_next  = r_last;
        w_hold_inc   = '0;
        if (rst) begin
            w_last_next = 1'b1;
        end else begin
            if (r_owner == OWN_R0 && req0) begin
                w_win0 = 1'b1;
            end else if (r_owner == OWN_R1 && req1) begin
                w_win1 = 1'b1;
            end else if (req0 && (!req1 || r_last)) begin
                w_win0 = 1'b1;
            end else if (req1) begin
                w_win1 = 1'b1;
            end

            if (w_win0) begin
                w_last_next = 1'b0;
                w_hold_inc  = (r_owner == OWN_R0) ? r_hold + ONE_W : ONE_W;
                if (lock0 && w_hold_inc < MAX_HOLD_W) begin
                    w_owner_next = OWN_R0;
                    w_hold_next  = w_hold_inc;
                end
            end else if (w_win1) begin
                w_last_next = 1'b1;
                w_hold_inc  = (r_owner == OWN_R1) ? r_hold + ONE_W : ONE_W;
                if (lock1 && w_hold_inc < MAX_HOLD_W) begin
                    w_owner_next = OWN_R1;
                    w_hold_next  = w_hold_inc;
                end
            end
        end
    end

    // Memory port mux: everything is zero when nobody is granted.
    always_comb begin
        gnt0         = w_win0;
        gnt1         = w_win1;
        address      = '0;
        memory_in    = '0;
        write_enable = '0;
        if (w_win0) begin
            address      = addr0;
            memory_in    = wdata0;
            write_enable = we0;
        end else if (w_win1) begin
            address      = addr1;
            memory_in    = wdata1;
            write_enable = we1;
        end
    end

    assign rdata0 = memory_out;
    assign rdata1 = memory_out;
    assign busy   = (r_owner != OWN_NONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level arbitration model.
module tb_mem_arbiter;

    localparam int MAX_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, lock0, lock1;
    logic [31:2] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  we0, we1;
    logic        gnt0, gnt1;
    logic [31:0] rdata0, rdata1;
    logic [31:2] address;
    logic [31:0] memory_in;
    logic [3:0]  write_enable;
    logic [31:0] memory_out;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Reference model state: owner -1 means nobody holds the port.
    int m_owner = -1;
    int m_hold  = 0;
    int m_last  = 1;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:2] a);
        if (a == 30'h10) return 32'hDEADBEEF;
        return {2'b00, a} ^ 32'h5A5A_0000;
    endfunction

    assign memory_out = mem_word(address);

    mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .gnt0(gnt0), .gnt1(gnt1),
        .rdata0(rdata0), .rdata1(rdata1), .address(address),
        .memory_in(memory_in), .write_enable(write_enable),
        .memory_out(memory_out), .busy(busy)
    );

    function automatic int exp_winner();
        if (rst) return -1;
        if (m_owner == 0 && req0) return 0;
        if (m_owner == 1 && req1) return 1;
        if (req0 && req1) return 1 - m_last;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_step();
        int w, nh;
        logic lk;
        w = exp_winner();
        if (rst) begin
            m_owner = -1; m_hold = 0; m_last = 1;
        end else if (w >= 0) begin
            nh = (m_owner == w) ? m_hold + 1 : 1;
            lk = (w == 0) ? lock0 : lock1;
            m_last = w;
            if (lk && nh < MAX_HOLD) begin
                m_owner = w; m_hold = nh;
            end else begin
                m_owner = -1; m_hold = 0;
            end
        end else begin
            m_owner = -1; m_hold = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; we0 = '0; we1 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1; lock1 = 1'b1;
        we0 = 4'hF; addr0 = 30'h5; wdata0 = 32'h1234_5678;
        settle();
        checks++;
        if ({gnt0, gnt1} !== 2'b00 || write_enable !== 4'h0 || address !== 30'h0 || memory_in !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b we=%h addr=%h min=%h, required all zero", {gnt0, gnt1}, write_enable, address, memory_in);
        end
        advance();
        settle();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: busy=%b required 0", busy);
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_single_read();
        idle_inputs();
        req0 = 1'b1; addr0 = 30'h10; we0 = 4'h0;
        settle();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || address !== 30'h10 || rdata0 !== 32'hDEADBEEF || write_enable !== 4'h0) begin
            failures++;
            $display("FAIL single_read: gnt0=%b gnt1=%b addr=%h rdata0=%h we=%h, required 1 0 10 deadbeef 0", gnt0, gnt1, address, rdata0, write_enable);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_tie();
        int exp_k;
        idle_inputs();
        rst = 1'b1;
        advance();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            exp_k = i % 2;
            checks++;
            if (gnt0 !== (exp_k == 0) || gnt1 !== (exp_k == 1)) begin
                failures++;
                $display("FAIL tie_cycle%0d: gnt0=%b gnt1=%b required R%0d only", i, gnt0, gnt1, exp_k);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_locked_pair();
        idle_inputs();
        req0 = 1'b1; lock0 = 1'b1; addr0 = 30'h20; we0 = 4'b1100; wdata0 = 32'hAAAA_0000;
        req1 = 1'b1; addr1 = 30'h30; we1 = 4'b1111;
        settle();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || write_enable !== 4'b1100 || address !== 30'h20 || memory_in !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL lock_first: gnt0=%b gnt1=%b we=%b addr=%h min=%h, required 1 0 1100 20 aaaa0000", gnt0, gnt1, write_enable, address, memory_in);
        end
        advance();
        addr0 = 30'h21; we0 = 4'b0011; wdata0 = 32'h0000_BBBB;
        settle();
        checks++;
        if (busy !== 1'b1 || gnt0 !== 1'b1 || gnt1 !== 1'b0 || write_enable !== 4'b0011 || address !== 30'h21) begin
            failures++;
            $display("FAIL lock_second: busy=%b gnt0=%b gnt1=%b we=%b addr=%h, required 1 1 0 0011 21", busy, gnt0, gnt1, write_enable, address);
        end
        advance();
        req0 = 1'b0; lock0 = 1'b0;
        settle();
        checks++;
        if (busy !== 1'b0 || gnt1 !== 1'b1 || gnt0 !== 1'b0 || write_enable !== 4'b1111) begin
            failures++;
            $display("FAIL lock_release: busy=%b gnt0=%b gnt1=%b we=%b, required 0 0 1 1111", busy, gnt0, gnt1, write_enable);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_hold_limit();
        int pat [5] = '{1, 1, 0, 1, 1};
        idle_inputs();
        req0 = 1'b1;
        advance();
        req1 = 1'b1; lock1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if (gnt0 !== (pat[i] == 0) || gnt1 !== (pat[i] == 1)) begin
                failures++;
                $display("FAIL hold_limit_cycle%0d: gnt0=%b gnt1=%b required R%0d", i, gnt0, gnt1, pat[i]);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_owner_drop();
        idle_inputs();
        req1 = 1'b1; lock1 = 1'b1;
        settle();
        checks++;
        if (gnt1 !== 1'b1) begin
            failures++;
            $display("FAIL drop_grant1: gnt1=%b required 1", gnt1);
        end
        advance();
        req1 = 1'b0; req0 = 1'b1;
        settle();
        checks++;
        if (busy !== 1'b1 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL drop_grant0: busy=%b gnt0=%b gnt1=%b required 1 1 0", busy, gnt0, gnt1);
        end
        advance();
        settle();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_busy: busy=%b required 0", busy);
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_reset_mid_lock();
        idle_inputs();
        req0 = 1'b1; lock0 = 1'b1; we0 = 4'hF;
        advance();
        settle();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midlock_busy: busy=%b required 1", busy);
        end
        rst = 1'b1; req1 = 1'b1; we1 = 4'hF;
        settle();
        checks++;
        if ({gnt0, gnt1} !== 2'b00 || write_enable !== 4'h0) begin
            failures++;
            $display("FAIL midlock_rst: gnt=%b we=%h required 00 0", {gnt0, gnt1}, write_enable);
        end
        advance();
        rst = 1'b0; lock0 = 1'b0;
        settle();
        checks++;
        if (busy !== 1'b0 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL midlock_after: busy=%b gnt0=%b gnt1=%b required 0 1 0", busy, gnt0, gnt1);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_random();
        int w;
        logic [31:2] ea;
        logic [31:0] ed;
        logic [3:0]  ewe;
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 31) == 0);
            req0   = ($urandom_range(0, 3) != 0);
            req1   = ($urandom_range(0, 3) != 0);
            lock0  = $urandom_range(0, 1);
            lock1  = $urandom_range(0, 1);
            addr0  = 30'($urandom_range(0, 255));
            addr1  = 30'($urandom_range(0, 255));
            wdata0 = $urandom;
            wdata1 = $urandom;
            we0    = 4'($urandom_range(0, 15));
            we1    = 4'($urandom_range(0, 15));
            settle();
            w = exp_winner();
            ea = (w == 0) ? addr0 : (w == 1) ? addr1 : 30'h0;
            ed = (w == 0) ? wdata0 : (w == 1) ? wdata1 : 32'h0;
            ewe = (w == 0) ? we0 : (w == 1) ? we1 : 4'h0;
            checks++;
            if (gnt0 !== (w == 0) || gnt1 !== (w == 1) || busy !== (m_owner >= 0)) begin
                failures++;
                $display("FAIL rand%0d_grant: gnt0=%b gnt1=%b busy=%b required winner=%0d busy=%b", i, gnt0, gnt1, busy, w, m_owner >= 0);
            end
            checks++;
            if (address !== ea || memory_in !== ed || write_enable !== ewe) begin
                failures++;
                $display("FAIL rand%0d_port: addr=%h min=%h we=%h required %h %h %h", i, address, memory_in, write_enable, ea, ed, ewe);
            end
            if (w >= 0) begin
                checks++;
                if ((w == 0 ? rdata0 : rdata1) !== mem_word(ea)) begin
                    failures++;
                    $display("FAIL rand%0d_rdata: got %h required %h", i, (w == 0 ? rdata0 : rdata1), mem_word(ea));
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_single_read();
        test_tie();
        test_locked_pair();
        test_hold_limit();
        test_owner_drop();
        test_reset_mid_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
